// File: rtl/uart_array_recv_if.sv
// Host-side serial line plus the assembled-array outputs of the array receiver.
interface uart_array_recv_if #(
  parameter int NU    = 10,
  parameter int WIDTH = 32
);
  logic                  rx;
  logic [NU*WIDTH-1:0]   arr_out;
  logic                  arr_valid;
  logic                  busy;
  logic                  frame_err;
  logic                  rx_timeout;
  logic [15:0]           byte_cnt;

  modport master (output rx, input arr_out, arr_valid, busy, frame_err, rx_timeout, byte_cnt);
  modport slave  (input rx, output arr_out, arr_valid, busy, frame_err, rx_timeout, byte_cnt);
endinterface

// File: rtl/uart_array_recv.sv
// 8N1 UART receiver packing NBYTES big-endian bytes into one array; arr_valid the clock after the last stop sample.
// No backpressure: arr_out is overwritten on every completion, the host paces the line.
module uart_array_recv #(
  parameter int NU           = 10,
  parameter int WIDTH        = 32,
  parameter int CLK_HZ       = 40000000,
  parameter int BAUD         = 115200,
  parameter int OVS          = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic             clk40mhz,
  input  logic             reset_n,
  uart_array_recv_if.slave bus
);
  localparam int W        = NU * WIDTH;
  localparam int NBYTES   = W / 8;
  localparam int DIV      = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
  localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW       = (OVS > 1) ? $clog2(OVS) : 1;
  // Prescaler is parked in IDLE, so the idle timeout counts raw clocks.
  localparam int TO_LIMIT = TIMEOUT_BITS * OVS * DIV;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state;
  logic            rx_meta, rx_s;
  logic [PW-1:0]   pre;
  logic [CW-1:0]   tcnt;
  logic [2:0]      bitn;
  logic [7:0]      shreg;
  logic [W-1:0]    asm_reg;
  logic [15:0]     bcnt;
  logic [TW-1:0]   idle_cnt;
  logic [W-1:0]    arr_q;
  logic            valid_q, ferr_q, tmo_q;
  logic            tick;
  logic [W-1:0]    asm_next;

  assign tick     = (pre == PW'(DIV - 1));
  assign asm_next = W'({asm_reg, shreg});

  always_ff @(posedge clk40mhz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      pre      <= '0;
      tcnt     <= '0;
      bitn     <= '0;
      shreg    <= '0;
      asm_reg  <= '0;
      bcnt     <= '0;
      idle_cnt <= '0;
      arr_q    <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      tmo_q   <= 1'b0;
      if (state == IDLE || tick) pre <= '0;
      else                       pre <= pre + PW'(1);

      case (state)
        IDLE: begin
          if (bcnt != 16'd0) begin
            if (idle_cnt == TW'(TO_LIMIT - 1)) begin
              idle_cnt <= '0;
              bcnt     <= '0;
              asm_reg  <= '0;
              tmo_q    <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + TW'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
          // A start edge coinciding with a timeout still begins byte 0.
          if (!rx_s) begin
            state    <= START;
            tcnt     <= '0;
            idle_cnt <= '0;
          end
        end
        START: if (tick) begin
          if (tcnt == CW'(OVS / 2 - 1)) begin
            tcnt  <= '0;
            bitn  <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DATA: if (tick) begin
          if (tcnt == CW'(OVS - 1)) begin
            tcnt  <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        STOP: if (tick) begin
          if (tcnt == CW'(OVS - 1)) begin
            tcnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (bcnt == 16'(NBYTES - 1)) begin
                arr_q   <= asm_next;
                valid_q <= 1'b1;
                bcnt    <= '0;
                asm_reg <= '0;
              end else begin
                asm_reg <= asm_next;
                bcnt    <= bcnt + 16'd1;
              end
            end else begin
              ferr_q <= 1'b1;
              state  <= WAIT_HIGH;
            end
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        WAIT_HIGH: if (rx_s) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign bus.arr_out    = arr_q;
  assign bus.arr_valid  = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.rx_timeout = tmo_q;
  assign bus.byte_cnt   = bcnt;
  assign bus.busy       = (state != IDLE) || (bcnt != 16'd0);
endmodule
